// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for a multi-slot in-order issue stage.
// Tracks in-flight writers and loads per architectural register and gates issue.
module hazard_scoreboard #(
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ISSUE_WIDTH-1:0]      issue_valid,
  input  logic [ISSUE_WIDTH-1:0][4:0] issue_rs1,
  input  logic [ISSUE_WIDTH-1:0][4:0] issue_rs2,
  input  logic [ISSUE_WIDTH-1:0][4:0] issue_rd,
  input  logic [ISSUE_WIDTH-1:0]      issue_regwrite,
  input  logic [ISSUE_WIDTH-1:0]      issue_is_load,
  output logic [ISSUE_WIDTH-1:0]      issue_ready,
  input  logic [ISSUE_WIDTH-1:0]      wb_valid,
  input  logic [ISSUE_WIDTH-1:0]      wb_is_load,
  input  logic [ISSUE_WIDTH-1:0][4:0] wb_rd,
  input  logic                        flush,
  output logic                        pending_any,
  output logic [15:0]                 stall_cycles,
  output logic                        sb_error
);

  // Wide enough to hold a counter plus every slot's increment without wrapping.
  localparam int SW = CNT_W + 4;
  typedef logic [SW-1:0] sum_t;
  localparam sum_t CNT_MAX = sum_t'({CNT_W{1'b1}});

  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic [CNT_W-1:0] load_q [32];
  logic [CNT_W-1:0] load_d [32];
  sum_t             pend_inc [32];
  sum_t             pend_dec [32];
  sum_t             load_inc [32];
  sum_t             load_dec [32];
  logic             err_q, err_d;
  logic [15:0]      stall_q, stall_d;
  logic [ISSUE_WIDTH-1:0] fire;
  logic             chain_ok, hz;
  sum_t             p_tot, l_tot;

  function automatic logic [CNT_W-1:0] clamp_hi(input sum_t v);
    return (v > CNT_MAX) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      pend_dec[r] = '0;
      load_dec[r] = '0;
    end
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (wb_valid[i] && wb_rd[i] == 5'(r)) begin
          pend_dec[r] = pend_dec[r] + sum_t'(1);
          if (wb_is_load[i]) load_dec[r] = load_dec[r] + sum_t'(1);
        end
      end
    end
  end

  // Handshake: slot i fires when issue_valid[i] and issue_ready[i] are both high
  // in the same cycle; ready is combinational and never depends on issue_valid[i].
  always_comb begin
    issue_ready = '0;
    hz          = 1'b0;
    chain_ok    = !flush;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      hz = 1'b0;
      // A load retiring this cycle may release the consumer early.
      if (issue_rs1[i] != 5'd0 && sum_t'(load_q[issue_rs1[i]]) > load_dec[issue_rs1[i]])
        hz = 1'b1;
      if (issue_rs2[i] != 5'd0 && sum_t'(load_q[issue_rs2[i]]) > load_dec[issue_rs2[i]])
        hz = 1'b1;
      if (issue_regwrite[i] && issue_rd[i] != 5'd0 && pend_q[issue_rd[i]] == {CNT_W{1'b1}})
        hz = 1'b1;
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (j < i && issue_valid[j] && issue_regwrite[j] && issue_rd[j] != 5'd0 &&
            (issue_rd[j] == issue_rs1[i] || issue_rd[j] == issue_rs2[i] ||
             issue_rd[j] == issue_rd[i]))
          hz = 1'b1;
      end
      chain_ok       = chain_ok && !hz;
      issue_ready[i] = chain_ok;
    end
  end

  assign fire = issue_valid & issue_ready;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      pend_inc[r] = '0;
      load_inc[r] = '0;
    end
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (fire[i] && issue_regwrite[i] && issue_rd[i] == 5'(r)) begin
          pend_inc[r] = pend_inc[r] + sum_t'(1);
          if (issue_is_load[i]) load_inc[r] = load_inc[r] + sum_t'(1);
        end
      end
    end
  end

  always_comb begin
    err_d       = err_q;
    pending_any = 1'b0;
    p_tot       = '0;
    l_tot       = '0;
    for (int r = 0; r < 32; r++) begin
      pend_d[r] = '0;
      load_d[r] = '0;
    end
    for (int r = 1; r < 32; r++) begin
      pending_any = pending_any | (pend_q[r] != '0);
      p_tot = sum_t'(pend_q[r]) + pend_inc[r];
      l_tot = sum_t'(load_q[r]) + load_inc[r];
      if (!flush) begin
        if (pend_dec[r] > p_tot) err_d = 1'b1;
        else                     pend_d[r] = clamp_hi(p_tot - pend_dec[r]);
        if (load_dec[r] > l_tot) err_d = 1'b1;
        else                     load_d[r] = clamp_hi(l_tot - load_dec[r]);
      end
    end
  end

  assign stall_d = (issue_valid[0] && !issue_ready[0] && stall_q != 16'hFFFF) ?
                   stall_q + 16'd1 : stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= '0;
        load_q[r] <= '0;
      end
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      load_q  <= load_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
  assign sb_error     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, bundle hazards, saturation,
// underflow, flush and asynchronous reset, all with hand-computed expectations.
module tb_hazard_scoreboard;

  logic            clock;
  logic            reset;
  logic [1:0]      issue_valid;
  logic [1:0][4:0] issue_rs1, issue_rs2, issue_rd;
  logic [1:0]      issue_regwrite, issue_is_load;
  logic [1:0]      issue_ready;
  logic [1:0]      wb_valid, wb_is_load;
  logic [1:0][4:0] wb_rd;
  logic            flush;
  logic            pending_any;
  logic [15:0]     stall_cycles;
  logic            sb_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_scoreboard #(.ISSUE_WIDTH(2), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_rd(wb_rd),
    .flush(flush), .pending_any(pending_any), .stall_cycles(stall_cycles),
    .sb_error(sb_error)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic clear_inputs();
    issue_valid = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    issue_regwrite = '0; issue_is_load = '0;
    wb_valid = '0; wb_is_load = '0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic ld);
    issue_valid[s] = 1'b1; issue_rs1[s] = rs1; issue_rs2[s] = rs2; issue_rd[s] = rd;
    issue_regwrite[s] = rw; issue_is_load[s] = ld;
  endtask

  task automatic set_wb(input int s, input logic [4:0] rd, input logic ld);
    wb_valid[s] = 1'b1; wb_rd[s] = rd; wb_is_load[s] = ld;
  endtask

  // Inputs change and outputs are sampled 2-3 time units after a rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #3;
    check("reset_pending_any", 32'(pending_any), 0);
    check("reset_stall", 32'(stall_cycles), 0);
    check("reset_sb_error", 32'(sb_error), 0);
    #4 reset = 1'b1;
    step();

    // Load-use stall, released by a same-cycle load writeback
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1); settle();
    check("lu_load_issue", 32'(issue_ready), 32'b11);
    step();
    clear_inputs(); set_slot(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); settle();
    check("lu_pending_any", 32'(pending_any), 1);
    check("lu_stall_ready", 32'(issue_ready[0]), 0);
    step();
    check("lu_stall_count", 32'(stall_cycles), 1);
    set_wb(0, 5'd5, 1'b0); settle();
    check("lu_nonload_wb_no_bypass", 32'(issue_ready[0]), 0);
    wb_is_load[0] = 1'b1; settle();
    check("lu_load_wb_bypass", 32'(issue_ready[0]), 1);
    step();
    clear_inputs(); settle();
    check("lu_drained", 32'(pending_any), 0);
    check("lu_stall_hold", 32'(stall_cycles), 1);

    // Intra-bundle RAW and WAW, evaluated combinationally without an edge
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    set_slot(1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0); settle();
    check("bundle_raw", 32'(issue_ready), 32'b01);
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    set_slot(1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0); settle();
    check("bundle_waw", 32'(issue_ready), 32'b01);

    // x0 is never a hazard and never tracked
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    set_slot(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); settle();
    check("x0_bundle", 32'(issue_ready), 32'b11);
    step();
    clear_inputs(); settle();
    check("x0_untracked", 32'(pending_any), 0);

    // Saturation at three outstanding writers to rd 7
    for (int k = 0; k < 3; k++) begin
      clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); settle();
      check($sformatf("sat_issue_%0d", k), 32'(issue_ready[0]), 1);
      step();
    end
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    set_slot(1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0); settle();
    check("sat_fourth_stall_in_order", 32'(issue_ready), 32'b00);
    step();
    set_wb(0, 5'd7, 1'b0); settle();
    check("sat_wb_same_cycle", 32'(issue_ready), 32'b00);
    step();
    wb_valid = '0; settle();
    check("sat_release", 32'(issue_ready), 32'b11);
    check("sat_stall_count", 32'(stall_cycles), 3);
    step();
    clear_inputs(); set_wb(0, 5'd7, 1'b0); set_wb(1, 5'd7, 1'b0); step();
    clear_inputs(); set_wb(0, 5'd7, 1'b0); set_wb(1, 5'd8, 1'b0); step();
    clear_inputs(); settle();
    check("sat_drained", 32'(pending_any), 0);
    check("sat_no_error", 32'(sb_error), 0);

    // Underflow sets the sticky error; asynchronous reset clears it
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); step();
    clear_inputs(); settle();
    check("uf_pending", 32'(pending_any), 1);
    set_wb(0, 5'd9, 1'b0); set_wb(1, 5'd9, 1'b0); step();
    clear_inputs(); settle();
    check("uf_clamped", 32'(pending_any), 0);
    check("uf_error", 32'(sb_error), 1);
    step();
    check("uf_sticky", 32'(sb_error), 1);
    reset = 1'b0; settle();
    check("async_reset_error", 32'(sb_error), 0);
    check("async_reset_stall", 32'(stall_cycles), 0);
    #1 reset = 1'b1;
    step();

    // Flush clears counters and ignores concurrent issue/writeback
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1); step();
    step();
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1); set_wb(0, 5'd9, 1'b0);
    flush = 1'b1; settle();
    check("flush_ready", 32'(issue_ready), 32'b00);
    step();
    clear_inputs(); set_slot(0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0); settle();
    check("flush_pending_any", 32'(pending_any), 0);
    check("flush_wb_ignored", 32'(sb_error), 0);
    check("flush_stall_counted", 32'(stall_cycles), 1);
    check("flush_load_cleared", 32'(issue_ready[0]), 1);
    step();

    // Reset released mid-stall: readiness follows zeroed state immediately
    clear_inputs(); set_slot(0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1); step();
    clear_inputs(); set_slot(0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0); settle();
    check("mid_stall_blocked", 32'(issue_ready[0]), 0);
    reset = 1'b0; settle();
    check("mid_stall_reset_pending", 32'(pending_any), 0);
    reset = 1'b1; settle();
    check("mid_stall_ready_after_reset", 32'(issue_ready[0]), 1);
    step();
    check("mid_stall_no_count", 32'(stall_cycles), 0);
    clear_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter ISSUE_WIDTH, default 2: number of issue and writeback slots; slot 0 is the oldest.
REQ-002 Parameter CNT_W, default 2: width of the per-register pending counters, so the maximum count is 3.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port issue_valid, input, [ISSUE_WIDTH]: instruction present in the slot.
REQ-006 Port issue_rs1 / issue_rs2, input, [ISSUE_WIDTH][5]: source register indices.
REQ-007 Port issue_rd, input, [ISSUE_WIDTH][5]: destination register index.
REQ-008 Port issue_regwrite / issue_is_load, input, [ISSUE_WIDTH]: the slot writes rd / the slot is a load.
REQ-009 Port issue_ready, output, [ISSUE_WIDTH]: the slot issues this cycle.
REQ-010 Port wb_valid / wb_is_load, input, [ISSUE_WIDTH]: a register writeback retires / the writeback came from a load.
REQ-011 Port wb_rd, input, [ISSUE_WIDTH][5]: retiring destination register.
REQ-012 Port flush, input, 1 bit: squash all in-flight producers.
REQ-013 Port pending_any, output, 1 bit: some register has pend_cnt > 0.
REQ-014 Port stall_cycles, output, 16 bits: saturating stall counter.
REQ-015 Port sb_error, output, 1 bit: sticky underflow flag.

Function
REQ-016 State: per register r in 1..31, pend_cnt[r] and load_cnt[r], each CNT_W bits; register x0 is never tracked and is never a hazard.
REQ-017 Fire: slot i fires when issue_valid[i] and issue_ready[i] are both 1; issue_ready is combinational from current state and current inputs.
REQ-018 Load-use: issue_ready[i] = 0 if a nonzero rs1 or rs2 of slot i has load_cnt > 0, unless the same cycle's retiring load writebacks to that register (wb_valid and wb_is_load) bring load_cnt to 0.
REQ-019 Intra-bundle RAW: issue_ready[i] = 0 if an older valid slot j < i has regwrite and a nonzero rd equal to rs1[i] or rs2[i].
REQ-020 Intra-bundle WAW: issue_ready[i] = 0 if an older valid regwrite slot j < i has the same nonzero rd.
REQ-021 Saturation: issue_ready[i] = 0 if issue_regwrite[i] is set and pend_cnt[rd] = 3.
REQ-022 In-order: issue_ready[i] = 0 if i > 0 and issue_ready[i-1] = 0.
REQ-023 Flush cycle: issue_ready = all 0 while flush = 1.
REQ-024 Counter update, next edge: pend_cnt[r] += fired regwrite slots with rd = r, and -= wb_valid slots with wb_rd = r.
REQ-025 load_cnt follows the same rule as pend_cnt, counting only is_load slots on issue and wb_is_load slots on writeback.
REQ-026 Simultaneous issue and writeback to the same register are both applied in one net update.
REQ-027 Underflow: a decrement below 0 clamps the counter to 0 and sets sb_error, which stays set until reset.
REQ-028 Flush: at the next edge all pend_cnt and load_cnt are cleared; same-cycle issue and writeback are ignored.
REQ-029 stall_cycles increments each cycle in which issue_valid[0] = 1 and issue_ready[0] = 0, saturating at 0xFFFF; flush does not clear it.
REQ-030 Latency: a fired producer is visible to hazard checks in the following cycle.

Reset
REQ-031 When reset is low, all counters are 0, sb_error = 0, stall_cycles = 0 and pending_any = 0, immediately and regardless of clock.
REQ-032 Reset deasserted mid-stall: issue_ready is a function of zeroed state from the first cycle after reset.

Verification
REQ-033 Load-use: slot 0 issues a load with rd = 5; next cycle slot 0 has rs1 = 5 -> issue_ready[0] = 0 and stall_cycles = 1. A load writeback to rd 5 in the following cycle -> issue_ready[0] = 1 in that same cycle.
REQ-034 Bundle RAW: slot 0 is a regwrite with rd = 3 and slot 1 has rs2 = 3 -> issue_ready = 2'b01.
REQ-035 Slot 1 reads x0 while slot 0 writes x0 -> issue_ready = 2'b11, and no counter changes.
REQ-036 Saturation: three ALU issues to rd = 7 with no writebacks, then a fourth -> the fourth stalls. One writeback to rd 7 -> the fourth issues next cycle.
REQ-037 Two writebacks to rd = 9 while pend_cnt[9] = 1 -> pend_cnt[9] = 0 and sb_error = 1. Reset -> sb_error = 0.
REQ-038 Flush with pend_cnt[4] = 2 and a concurrent issue to rd 4 -> all counters are 0 next cycle and pending_any = 0.
